// File: rtl/rule110_row_engine.sv
// -----------------------------------------------------------------------------
// rule110_row_engine
//
// Storage and sequencing around the Rule 110 cellular automaton. A row of
// WIDTH cells is loaded serially, advanced one generation per clock for a
// requested number of generations, and streamed back out MSB first. The
// readout rotates the row, so it holds its original contents after a read.
//
// Parameters
//   WIDTH       number of cells in the row (3..64)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   load_valid  in IDLE: shift load_bit into row[0]
//   load_bit    serial cell value to load
//   start       in IDLE: run `gens` generations (highest priority)
//   gens        generation count, sampled when start is accepted
//   read_start  in IDLE: stream the row out serially
//   busy        high while in RUN or READ
//   done        one-cycle pulse after a generation run completes
//   out_valid   high while out_bit carries a row cell
//   out_bit     serial cell value, cell WIDTH-1 first; 0 when not valid
//
// Configuration
//   RULE110_WRAP_EN  defined: circular row (row[WIDTH]=row[0],
//                    row[-1]=row[WIDTH-1]); undefined: out-of-range
//                    neighbours read as 0.
// -----------------------------------------------------------------------------
module rule110_row_engine #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic       load_bit,
  input  logic       start,
  input  logic [7:0] gens,
  input  logic       read_start,
  output logic       busy,
  output logic       done,
  output logic       out_valid,
  output logic       out_bit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_READ = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   row_q,   row_d;
  logic [7:0]         cnt_q,   cnt_d;
  logic               done_q,  done_d;

  logic               left_edge;   // neighbour seen by cell WIDTH-1
  logic               right_edge;  // neighbour seen by cell 0
  logic [WIDTH+1:0]   row_ext;     // row padded with its edge neighbours
  logic [WIDTH-1:0]   row_next_gen;

  // Rule 110: 0 for neighbourhoods 000, 100, 111; 1 otherwise.
  // Equivalent to (C | R) & ~(L & C & R).
  function automatic logic rule110(input logic [2:0] lcr);
    return (lcr[1] | lcr[0]) & ~(&lcr);
  endfunction

`ifdef RULE110_WRAP_EN
  assign left_edge  = row_q[0];
  assign right_edge = row_q[WIDTH-1];
`else
  assign left_edge  = 1'b0;
  assign right_edge = 1'b0;
`endif

  assign row_ext = {left_edge, row_q, right_edge};

  // Cell i sits at row_ext[i+1]; its {L,C,R} window is row_ext[i+2:i].
  always_comb begin
    row_next_gen = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row_next_gen[i] = rule110(row_ext[i+2 -: 3]);
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // start > read_start > load_valid; lower requests are dropped.
        if (start) begin
          if (gens == 8'd0) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = gens;
            state_d = S_RUN;
          end
        end else if (read_start) begin
          cnt_d   = 8'(WIDTH);
          state_d = S_READ;
        end else if (load_valid) begin
          row_d = {row_q[WIDTH-2:0], load_bit};
        end
      end

      S_RUN: begin
        row_d = row_next_gen;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      S_READ: begin
        // Rotate rather than shift so WIDTH reads restore the row.
        row_d = {row_q[WIDTH-2:0], row_q[WIDTH-1]};
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_valid = (state_q == S_READ);
  assign out_bit   = out_valid & row_q[WIDTH-1];

endmodule

// File: tb/tb_rule110_row_engine.sv
// -----------------------------------------------------------------------------
// tb_rule110_row_engine
//
// Self-checking bench for rule110_row_engine with WIDTH=8. Directed cases
// cover reset, the known single-generation results in the selected boundary
// mode, gens=0, start/read_start collision and reset during a run. A random
// phase of loads, runs and reads is then compared against a reference model
// that evaluates Rule 110 from its rule number on a plain bit array.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rule110_row_engine;

  localparam int W = 8;
`ifdef RULE110_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic       load_bit;
  logic       start;
  logic [7:0] gens;
  logic       read_start;
  logic       busy;
  logic       done;
  logic       out_valid;
  logic       out_bit;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_row;  // reference copy of the row

  rule110_row_engine #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_bit   (load_bit),
    .start      (start),
    .gens       (gens),
    .read_start (read_start),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_bit    (out_bit)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one Rule 110 generation. Bit k of the rule number 110 is the
  // new cell value for neighbourhood value k = 4*L + 2*C + R.
  function automatic logic [W-1:0] ref_gen(input logic [W-1:0] r);
    logic [W-1:0] n;
    int l, c, rr, k;
    n = '0;
    for (int i = 0; i < W; i++) begin
      c  = int'(r[i]);
      l  = (i == W-1) ? (WRAP ? int'(r[0])   : 0) : int'(r[i+1]);
      rr = (i == 0)   ? (WRAP ? int'(r[W-1]) : 0) : int'(r[i-1]);
      k  = 4*l + 2*c + rr;
      n[i] = ((110 >> k) & 1) == 1;
    end
    return n;
  endfunction

  task automatic clear_inputs();
    load_valid = 1'b0;
    load_bit   = 1'b0;
    start      = 1'b0;
    gens       = 8'd0;
    read_start = 1'b0;
  endtask

  // Requests that must be ignored because the engine is not in IDLE.
  task automatic drive_junk();
    load_valid = 1'($urandom_range(0, 1));
    load_bit   = 1'($urandom_range(0, 1));
    start      = 1'($urandom_range(0, 1));
    gens       = 8'($urandom_range(0, 255));
    read_start = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  busy,      1'b0);
    check({tag, "_done"},  done,      1'b0);
    check({tag, "_ovld"},  out_valid, 1'b0);
    check({tag, "_obit"},  out_bit,   1'b0);
  endtask

  task automatic do_load(input logic b);
    load_valid = 1'b1;
    load_bit   = b;
    step();
    clear_inputs();
    m_row = {m_row[W-2:0], b};
    check("load_busy", busy, 1'b0);
  endtask

  task automatic load_row(input logic [W-1:0] v);
    for (int i = W-1; i >= 0; i--) do_load(v[i]);
  endtask

  // Start a run; optionally assert read_start and load_valid alongside to
  // show that start wins. Checks busy/done timing and no readout.
  task automatic do_run(input int g, input bit collide, input bit junk);
    start      = 1'b1;
    gens       = 8'(g);
    read_start = collide;
    load_valid = collide;
    load_bit   = 1'b1;
    step();
    clear_inputs();
    if (g == 0) begin
      check("g0_done", done,      1'b1);
      check("g0_busy", busy,      1'b0);
      check("g0_ovld", out_valid, 1'b0);
    end else begin
      for (int k = 0; k < g; k++) begin
        check("run_busy", busy,      1'b1);
        check("run_done", done,      1'b0);
        check("run_ovld", out_valid, 1'b0);
        check("run_obit", out_bit,   1'b0);
        if (junk) drive_junk();
        step();
        clear_inputs();
      end
      check("run_done_pulse", done, 1'b1);
      check("run_end_busy",   busy, 1'b0);
      for (int k = 0; k < g; k++) m_row = ref_gen(m_row);
    end
    step();
    check("done_one_cycle", done, 1'b0);
  endtask

  // Read the row out and compare the stream to exp, MSB first.
  task automatic do_read(input string tag, input logic [W-1:0] exp, input bit junk);
    read_start = 1'b1;
    step();
    clear_inputs();
    for (int k = 0; k < W; k++) begin
      check({tag, "_ovld"}, out_valid, 1'b1);
      check({tag, "_busy"}, busy,      1'b1);
      check({tag, "_bit"},  out_bit,   exp[W-1-k]);
      if (junk) drive_junk();
      step();
      clear_inputs();
    end
    check({tag, "_end_ovld"}, out_valid, 1'b0);
    check({tag, "_end_obit"}, out_bit,   1'b0);
    check({tag, "_end_busy"}, busy,      1'b0);
  endtask

  initial begin
    clear_inputs();
    m_row = '0;
    rst_n = 1'b0;
    #1;
    check_idle("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet after reset, then an all-zero read.
    for (int i = 0; i < 16; i++) begin
      step();
      check_idle("quiet");
    end
    do_read("rd_zero", '0, 1'b0);

    // Single seed at cell 0: identical in both boundary modes.
    load_row(8'b0000_0001);
    do_run(1, 1'b0, 1'b0);
    do_read("rd_seed0", 8'b0000_0011, 1'b0);

    // Seed at cell WIDTH-1: depends on boundary mode.
    load_row(8'b1000_0000);
    do_run(1, 1'b0, 1'b0);
    do_read("rd_seed7", WRAP ? 8'b1000_0001 : 8'b1000_0000, 1'b0);

    // All ones; read twice to show readout preserves the row.
    load_row(8'b1111_1111);
    do_run(1, 1'b0, 1'b0);
    do_read("rd_ones_a", WRAP ? 8'b0000_0000 : 8'b1000_0001, 1'b0);
    do_read("rd_ones_b", WRAP ? 8'b0000_0000 : 8'b1000_0001, 1'b0);

    // gens=0: done next cycle, row unchanged.
    load_row(8'b1011_0010);
    do_run(0, 1'b0, 1'b0);
    do_read("rd_g0", 8'b1011_0010, 1'b0);

    // start together with read_start/load_valid: only the run happens.
    do_run(3, 1'b1, 1'b0);
    do_read("rd_collide", m_row, 1'b0);

    // Reset during a long run.
    start = 1'b1;
    gens  = 8'd200;
    step();
    clear_inputs();
    for (int k = 0; k < 5; k++) step();
    check("midrun_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_row = '0;
    step();
    check_idle("post_rst");
    do_read("rd_post_rst", '0, 1'b0);

    // Random traffic against the reference model.
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 6) begin
        do_load(1'($urandom_range(0, 1)));
      end else if (op < 8) begin
        do_run($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        do_read("rd_rand", m_row, 1'b1);
      end
    end
    do_read("rd_final", m_row, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rule110_row_engine.md
# rule110_row_engine

Sequential row engine for the Rule 110 cellular automaton. It holds a row of `WIDTH` cells and loads it serially. It advances the row a requested number of generations, one generation per clock, and streams the row back out serially in the order it was loaded. It is the storage and sequencing side around the per-cell Rule 110 function, and sits between the tile's pin-level I/O and the automaton logic.

## Interface

Parameters
- `WIDTH`, 16: number of cells in the row; legal range 3..64.

Ports
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load_valid` input 1: in IDLE, shifts `load_bit` into the row this cycle.
- `load_bit` input 1: serial cell value to load.
- `start` input 1: in IDLE, requests `gens` generations.
- `gens` input 8: generation count, sampled only when `start` is accepted.
- `read_start` input 1: in IDLE, requests serial readout of the row.
- `busy` output 1: high while in RUN or READ.
- `done` output 1: one-cycle pulse when a generation run completes.
- `out_valid` output 1: high while `out_bit` carries a row cell.
- `out_bit` output 1: serial cell value, MSB (cell `WIDTH-1`) first.

## Operation

- States are IDLE, RUN and READ. Internal state is `row[WIDTH-1:0]` plus a down-counter `cnt` (8 bits, enough for `WIDTH` ≤ 64 and `gens` ≤ 255).
- Reset values: state IDLE, `row`=0, `cnt`=0, `busy`=0, `done`=0, `out_valid`=0, `out_bit`=0.
- Priority in IDLE: `start` > `read_start` > `load_valid`. Only the highest-priority request is acted on; the lower ones are dropped, not queued.
- Load (IDLE, `load_valid`=1): `row <= {row[WIDTH-2:0], load_bit}`. After `WIDTH` loads, the first bit loaded sits in cell `WIDTH-1`.
- Start (IDLE, `start`=1):
  - `gens`=0: stay in IDLE, pulse `done` in the next cycle, leave `row` unchanged.
  - `gens`>0: `cnt <= gens`, go to RUN.
- RUN, on each edge:
  - All cells update in parallel: `row[i] <= rule110({L,C,R})` with L=`row[i+1]`, C=`row[i]`, R=`row[i-1]`.
  - rule110 gives 0 for neighbourhoods 000, 100 and 111, and 1 for all others.
  - `cnt <= cnt-1`. When `cnt`==1, go to IDLE and set `done`=1 for one cycle.
- Edge neighbours (`row[WIDTH]`, `row[-1]`) are set by the Configuration section.
- READ entry (IDLE, `read_start`=1): `cnt <= WIDTH`, go to READ.
- READ, each cycle:
  - `out_valid`=1, `out_bit`=`row[WIDTH-1]`.
  - On the edge, `row` rotates left by one (`{row[WIDTH-2:0], row[WIDTH-1]}`) and `cnt` decrements.
  - When `cnt`==1, go to IDLE.
  - After exactly `WIDTH` bits, `row` equals its pre-read value.
- `load_valid`, `start` and `read_start` are ignored outside IDLE.
- Reset asserted in any state returns to IDLE with all reset values. The row contents are lost.

## Timing

- Start accepted at edge T with G>0:
  - Generations are applied at edges T+1..T+G.
  - `busy`=1 during cycles T+1..T+G.
  - `done`=1 in the cycle after edge T+G.
  - A new `start` is accepted at edge T+G+1 at the earliest.
- Start accepted at edge T with G=0: `done`=1 in the cycle after T; `busy` stays 0.
- Read accepted at edge T: `out_valid`=1 for cycles T+1..T+WIDTH, giving cell `WIDTH-1` down to cell 0. `busy` matches `out_valid`.
- `out_bit` is 0 whenever `out_valid`=0.
- Load latency is one edge: the row is visible to a read requested on the next cycle.

## Configuration

- `RULE110_WRAP_EN` defined: the row is circular. `row[WIDTH]` is `row[0]` and `row[-1]` is `row[WIDTH-1]`.
- `RULE110_WRAP_EN` undefined: fixed boundary. Both out-of-range neighbours read as 0.

## Test plan

- Reset, then all outputs checked for 16 cycles with no requests: `busy`/`done`/`out_valid`/`out_bit` = 0. A read then returns 16 zeros.
- `WIDTH`=8, load 00000001, `start` with `gens`=1, then read: `done` pulses once and the read stream is 0,0,0,0,0,0,1,1. The result is identical in both configurations.
- `WIDTH`=8, load 10000000, `gens`=1, then read: with `RULE110_WRAP_EN` the result is 10000001; without it the result is 10000000.
- `WIDTH`=8, load 11111111, `gens`=1: with `RULE110_WRAP_EN` the row becomes 00000000; without it 10000001. A second read returns the same value, confirming the row is preserved by readout.
- `gens`=0 → `done` pulses in the next cycle, `busy` stays 0 and the row is unchanged. `start` and `read_start` in the same cycle → only RUN executes, with no `out_valid`.
- Reset asserted mid-RUN (`gens`=200, after 5 cycles) → next cycle is IDLE with `busy`=0 and no `done`. A read returns all zeros.
